config_frame_sequencer: RTL and testbench
=========================================

// Module: config_frame_sequencer
// PURPOSE
//   Bitstream-side controller that drives the FrameData/FrameStrobe configuration chain through the fabric tile columns.
//   Accepts a stream of 32-bit command/data words over a valid/ready handshake.
//   Each frame write is one header word followed by one data word; the header is validated first.
//   Frame data is presented on FrameData, then a one-hot strobe is pulsed on the addressed column/frame.
//   Sits between the bitstream loader and the top row of FrameData/FrameStrobe inputs of the fabric.
// PARAMETERS
//   FrameBitsPerRow   32  width of FrameData bus (one data word per frame write)
//   MaxFramesPerCol   20  strobe lines per column
//   NumColumns        4   number of tile columns; FrameStrobe = NumColumns*MaxFramesPerCol bits
//   StrobeHoldCycles  2   cycles the strobe bit stays high (>=1)
// PORTS
//   CLK             in   1                            fabric configuration clock, rising edge
//   RESET           in   1                            asynchronous, active-high reset
//   s_data          in   32                           command/data word
//   s_valid         in   1                            s_data valid
//   s_ready         out  1                            word accepted when s_valid && s_ready at CLK edge
//   FrameData       out  FrameBitsPerRow              registered frame data to fabric row
//   FrameStrobe     out  NumColumns*MaxFramesPerCol   one-hot strobe, bit = col*MaxFramesPerCol+frame
//   busy            out  1                            high in any state but IDLE
//   error           out  1                            sticky: bad header seen
//   frames_written  out  16                           count of completed strobes, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset values (async, take effect immediately): state=IDLE, FrameData=0, FrameStrobe=0, error=0,
//     frames_written=0, busy=0. A strobe in flight drops at once; the partial frame is lost.
//   Header: [31:24]=8'hFA magic, [23:16]=column, [15:8]=frame, [7:0]=reserved (ignored).
//   s_ready = (state==IDLE || state==DATA); s_ready is combinational from state only, never from s_valid.
//   States:
//     IDLE   : on header handshake, if the header is valid then latch col/frame and go to DATA;
//              otherwise set error=1 and stay IDLE (word discarded).
//              Header is invalid if magic!=FA, column>=NumColumns or frame>=MaxFramesPerCol.
//     DATA   : on handshake, FrameData<=s_data and go to SETUP. Waits indefinitely without s_valid.
//     SETUP  : 1 cycle; FrameData stable, FrameStrobe=0; then go to STROBE.
//     STROBE : FrameStrobe[col*MaxFramesPerCol+frame]=1, all other bits 0, for exactly StrobeHoldCycles cycles
//              (counted by an internal down-counter).
//              On exit, frames_written++ (16-bit wrap) and go to HOLD.
//     HOLD   : 1 cycle; FrameStrobe=0, FrameData held; then go to IDLE.
//   Latency: data handshake at edge k -> FrameData valid after edge k; strobe high after edge k+1
//     through edge k+1+StrobeHoldCycles; s_ready is high again after edge k+2+StrobeHoldCycles.
//   FrameData holds its last value in IDLE; it changes only at a DATA handshake.
//   FrameStrobe is registered and glitch-free; at most one bit is high at any time.
//   error is sticky until RESET and does not block further valid headers.
//   The data word is never checked against the magic value (any 32-bit value is legal data).
// TESTING
//   1 RESET mid-STROBE -> FrameStrobe==0 and busy==0 in the same cycle; error, frames_written and FrameData read 0.
//   2 header 32'hFA020500, data 32'hDEADBEEF, NumColumns=4, MaxFramesPerCol=20 ->
//     FrameData=DEADBEEF; FrameStrobe bit 45 high exactly 2 cycles after 1 SETUP cycle; frames_written=1.
//   3 header 32'hFB000000 -> error=1, s_ready stays 1, no strobe;
//     then valid header 32'hFA000000 + data 32'h1 -> bit 0 strobed, error still 1.
//   4 header with column=4, then one with frame=20 -> error=1 each time, no strobe, state stays IDLE.
//   5 s_valid held high over 3 back-to-back frame writes -> s_ready low for 2+StrobeHoldCycles cycles per frame;
//     strobes on the correct bits in order; frames_written=3.
//   6 preload frames_written=0xFFFF via 65535 writes (or force), one more write -> frames_written=0x0000.

Source files
------------

// File: rtl/config_frame_sequencer.sv
// Configuration frame sequencer: takes header/data word pairs from the
// bitstream loader and drives FrameData plus a one-hot FrameStrobe pulse.
module config_frame_sequencer #(
    parameter int FrameBitsPerRow  = 32,
    parameter int MaxFramesPerCol  = 20,
    parameter int NumColumns       = 4,
    parameter int StrobeHoldCycles = 2
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [31:0]                           s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [FrameBitsPerRow-1:0]            FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  error,
    output logic [15:0]                           frames_written
);

    localparam int SW = NumColumns * MaxFramesPerCol;
    localparam int IW = (SW > 1) ? $clog2(SW) : 1;
    localparam int CW = (NumColumns > 1) ? $clog2(NumColumns) : 1;
    localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int HW = $clog2(StrobeHoldCycles + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic [FW-1:0]              frame_q, frame_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [SW-1:0]              strobe_q, strobe_d;
    logic [HW-1:0]              cnt_q, cnt_d;
    logic                       error_q, error_d;
    logic [15:0]                frames_written_q, frames_written_d;

    logic          handshake;
    logic          hdr_ok;
    logic [IW-1:0] strobe_idx;
    logic [SW-1:0] strobe_onehot;

    // Ready depends only on state so the loader never sees a loop through s_valid.
    assign s_ready = (state_q == S_IDLE) || (state_q == S_DATA);
    assign busy    = (state_q != S_IDLE);

    assign FrameData      = frame_data_q;
    assign FrameStrobe    = strobe_q;
    assign error          = error_q;
    assign frames_written = frames_written_q;

    // Header decode and strobe bit position for the latched column/frame.
    always_comb begin
        handshake     = s_valid && s_ready;
        hdr_ok        = (s_data[31:24] == 8'hFA)
                     && (s_data[23:16] < 8'(NumColumns))
                     && (s_data[15:8] < 8'(MaxFramesPerCol));
        strobe_idx    = IW'(col_q) * IW'(MaxFramesPerCol) + IW'(frame_q);
        strobe_onehot = SW'(1) << strobe_idx;
    end

    // Next-state logic; the strobe register is loaded only when the next state is STROBE.
    always_comb begin
        state_d          = state_q;
        col_d            = col_q;
        frame_d          = frame_q;
        frame_data_d     = frame_data_q;
        strobe_d         = '0;
        cnt_d            = cnt_q;
        error_d          = error_q;
        frames_written_d = frames_written_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    if (hdr_ok) begin
                        col_d   = s_data[16 +: CW];
                        frame_d = s_data[8 +: FW];
                        state_d = S_DATA;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (handshake) begin
                    frame_data_d = FrameBitsPerRow'(s_data);
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d    = HW'(StrobeHoldCycles - 1);
                strobe_d = strobe_onehot;
                state_d  = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    frames_written_d = frames_written_q + 16'd1;
                    state_d          = S_HOLD;
                end else begin
                    cnt_d    = cnt_q - HW'(1);
                    strobe_d = strobe_onehot;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any strobe immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q          <= S_IDLE;
            col_q            <= '0;
            frame_q          <= '0;
            frame_data_q     <= '0;
            strobe_q         <= '0;
            cnt_q            <= '0;
            error_q          <= 1'b0;
            frames_written_q <= 16'd0;
        end else begin
            state_q          <= state_d;
            col_q            <= col_d;
            frame_q          <= frame_d;
            frame_data_q     <= frame_data_d;
            strobe_q         <= strobe_d;
            cnt_q            <= cnt_d;
            error_q          <= error_d;
            frames_written_q <= frames_written_d;
        end
    end

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Bench for config_frame_sequencer: directed cases plus randomized frame
// writes checked against a transaction-level model of header rules and timing.
module tb_config_frame_sequencer;

    localparam int NC  = 4;
    localparam int MF  = 20;
    localparam int SHC = 2;
    localparam int SW  = NC * MF;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   FrameData;
    logic [SW-1:0] FrameStrobe;
    logic          busy;
    logic          error;
    logic [15:0]   frames_written;

    int checks = 0;
    int errors = 0;

    // Model state: sticky error, completed-frame count, last data word.
    logic        err_m;
    logic [15:0] fw_m;
    logic [31:0] fd_m;

    config_frame_sequencer #(
        .FrameBitsPerRow(32),
        .MaxFramesPerCol(MF),
        .NumColumns(NC),
        .StrobeHoldCycles(SHC)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .busy(busy),
        .error(error),
        .frames_written(frames_written)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_static(input string tag);
        chk({tag, "_fd"}, 96'(FrameData), 96'(fd_m));
        chk({tag, "_fw"}, 96'(frames_written), 96'(fw_m));
        chk({tag, "_err"}, 96'(error), 96'(err_m));
    endtask

    // Present a word and wait (bounded) for the handshake edge; returns #1 after it.
    task automatic put(input logic [31:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_timeout", 96'(s_ready), 96'(1));
        @(posedge CLK);
        #1;
    endtask

    // One header/data transaction; expected behaviour derived from the header rules.
    task automatic frame(input logic [31:0] hdr, input logic [31:0] dat,
                         input int gap, input bit keep);
        int  c, f, idx;
        bit  ok;
        logic [95:0] exp_s;
        c  = int'(hdr[23:16]);
        f  = int'(hdr[15:8]);
        ok = (hdr[31:24] == 8'hFA) && (c < NC) && (f < MF);
        put(hdr);
        if (!ok) begin
            err_m = 1'b1;
            chk("bad_ready", 96'(s_ready), 96'(1));
            chk("bad_busy", 96'(busy), 96'(0));
            chk("bad_strobe", 96'(FrameStrobe), 96'(0));
            chk_static("bad");
            if (!keep) s_valid = 1'b0;
            return;
        end
        chk("hdr_busy", 96'(busy), 96'(1));
        chk("hdr_ready", 96'(s_ready), 96'(1));
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(posedge CLK);
            #1;
            chk("wait_busy", 96'(busy), 96'(1));
            chk("wait_ready", 96'(s_ready), 96'(1));
            chk("wait_strobe", 96'(FrameStrobe), 96'(0));
        end
        put(dat);
        fd_m = dat;
        idx  = c * MF + f;
        for (int i = 0; i <= SHC + 2; i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #1;
            end
            exp_s = (i >= 1 && i <= SHC) ? (96'(1) << idx) : 96'(0);
            if (i == SHC + 1) fw_m = fw_m + 16'd1;
            chk("strobe", 96'(FrameStrobe), exp_s);
            chk("ready", 96'(s_ready), 96'(i == SHC + 2));
            chk("busy", 96'(busy), 96'(i != SHC + 2));
            chk_static("frm");
        end
        if (!keep) s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  mg, cc, ff;
        logic [31:0] d;
        RESET   = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        err_m   = 1'b0;
        fw_m    = 16'd0;
        fd_m    = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_strobe", 96'(FrameStrobe), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_ready", 96'(s_ready), 96'(1));
        chk_static("rst");
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Column 2, frame 5 -> strobe bit 45.
        frame(32'hFA020500, 32'hDEADBEEF, 0, 1'b0);

        // Bad magic, then a good frame at bit 0; error stays set.
        frame(32'hFB000000, 32'h0, 0, 1'b0);
        frame(32'hFA000000, 32'h00000001, 0, 1'b0);

        // Column and frame out of range.
        frame(32'hFA040000, 32'h0, 0, 1'b0);
        frame(32'hFA001400, 32'h0, 0, 1'b0);

        // Back-to-back writes with s_valid held high.
        frame(32'hFA031300, 32'hFA031300, 0, 1'b1);
        frame(32'hFA010A7F, 32'h12345678, 0, 1'b1);
        frame(32'hFA0000FF, 32'h0BADF00D, 0, 1'b0);

        // Randomized writes, including invalid headers and gaps before data.
        for (int k = 0; k < 40; k++) begin
            mg = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFA;
            cc = 8'($urandom_range(0, NC + 1));
            ff = 8'($urandom_range(0, MF + 3));
            d  = $urandom;
            frame({mg, cc, ff, 8'($urandom)}, d, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
        end
        s_valid = 1'b0;
        @(posedge CLK);
        #1;

        // Counter wrap from 0xFFFF.
        force dut.frames_written_q = 16'hFFFF;
        #1;
        release dut.frames_written_q;
        fw_m = 16'hFFFF;
        chk("preload_fw", 96'(frames_written), 96'(16'hFFFF));
        frame(32'hFA030A00, 32'hCAFEF00D, 0, 1'b0);
        chk("wrap_fw", 96'(frames_written), 96'(0));

        // Reset while the strobe is high.
        put(32'hFA011200);
        put(32'h55AA55AA);
        s_valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("pre_rst_strobe", 96'(FrameStrobe), 96'(1) << (1 * MF + 18));
        RESET = 1'b1;
        #1;
        err_m = 1'b0;
        fw_m  = 16'd0;
        fd_m  = 32'd0;
        chk("mid_rst_strobe", 96'(FrameStrobe), 96'(0));
        chk("mid_rst_busy", 96'(busy), 96'(0));
        chk_static("mid_rst");
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        frame(32'hFA000100, 32'h00000042, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
